// File: rtl/lc3_mio_gen.sv
// LC-3 memory/IO unit: MAR/MDR, latency-counted memory accesses, keyboard FIFO and display port.
// Optional keyboard interrupt enable (KBSR[14]) and KB_INT output under `MIO_KB_INT_EN.
module lc3_mio_gen #(
    parameter int unsigned MEM_LAT  = 3,
    parameter int unsigned KB_DEPTH = 4,
    parameter logic [15:0] DEV_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] DATABUS,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        GateMDR,
    output logic [15:0] MDRbus_out,
    output logic        R,
    output logic        KB_INT,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    input  logic        disp_ready,
    output logic        LD_char,
    output logic [7:0]  I_char,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned PtrW = $clog2(KB_DEPTH);

    typedef enum logic [1:0] {StIdle, StMemWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       mar_q, mdr_q, rdata_q;
    logic              ld_char_q;
    logic [7:0]        i_char_q;

    logic [7:0]        fifo_mem [KB_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]     count_q;

    logic              ie;
    logic              dev_page, dev_hit, dev_start;
    logic              is_kbsr, is_kbdr, is_dsr, is_ddr;
    logic              kb_nonempty, kb_full, push, pop, ddr_load;
    logic [7:0]        head;
    logic [15:0]       dev_rdata;

    always_comb begin
        dev_page    = (mar_q[15:3] == DEV_BASE[15:3]);
        dev_hit     = dev_page && !mar_q[0];
        is_kbsr     = dev_hit && (mar_q[2:1] == 2'd0);
        is_kbdr     = dev_hit && (mar_q[2:1] == 2'd1);
        is_dsr      = dev_hit && (mar_q[2:1] == 2'd2);
        is_ddr      = dev_hit && (mar_q[2:1] == 2'd3);
        // Device side effects fire only on the IDLE->DONE edge.
        dev_start   = (state_q == StIdle) && MIO_EN && dev_page;
        kb_nonempty = (count_q != '0);
        kb_full     = (count_q == (PtrW+1)'(KB_DEPTH));
        head        = fifo_mem[rd_ptr_q];
        push        = kb_valid && !kb_full;
        pop         = dev_start && !R_W && is_kbdr && kb_nonempty;
        ddr_load    = dev_start && R_W && is_ddr && disp_ready;

        dev_rdata = 16'h0000;
        if (!R_W) begin
            if (is_kbsr)                     dev_rdata = {kb_nonempty, ie, 14'b0};
            else if (is_kbdr && kb_nonempty) dev_rdata = {8'h00, head};
            else if (is_dsr)                 dev_rdata = {disp_ready, 15'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        R       = 1'b0;
        case (state_q)
            StIdle: begin
                if (MIO_EN) begin
                    if (dev_page) begin
                        state_d = StDone;
                    end else begin
                        state_d = StMemWait;
                        cnt_d   = CntW'(MEM_LAT - 1);
                    end
                end
            end
            StMemWait: begin
                mem_en = 1'b1;
                mem_we = R_W;
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StDone: begin
                R = 1'b1;
                if (!MIO_EN) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            mar_q     <= 16'h0000;
            mdr_q     <= 16'h0000;
            rdata_q   <= 16'h0000;
            ld_char_q <= 1'b0;
            i_char_q  <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (LD_MAR) mar_q <= DATABUS;
            if (MIO_EN && (state_q == StDone) && LD_MDR && !R_W) mdr_q <= rdata_q;
            else if (!MIO_EN && LD_MDR)                          mdr_q <= DATABUS;
            if ((state_q == StMemWait) && (cnt_q == '0)) rdata_q <= mem_rdata;
            else if (dev_start)                          rdata_q <= dev_rdata;
            ld_char_q <= ddr_load;
            if (ddr_load) i_char_q <= mdr_q[7:0];
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= kb_data;
    end

`ifdef MIO_KB_INT_EN
    logic ie_q, kb_int_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            ie_q     <= 1'b0;
            kb_int_q <= 1'b0;
        end else begin
            if (dev_start && R_W && is_kbsr) ie_q <= mdr_q[14];
            kb_int_q <= kb_nonempty && ie_q;
        end
    end
    assign ie     = ie_q;
    assign KB_INT = kb_int_q;
`else
    assign ie     = 1'b0;
    assign KB_INT = 1'b0;
`endif

    assign MDRbus_out = GateMDR ? mdr_q : 16'h0000;
    assign kb_ready   = !kb_full;
    assign LD_char    = ld_char_q;
    assign I_char     = i_char_q;
    assign mem_addr   = mar_q;
    assign mem_wdata  = mdr_q;

endmodule

// File: tb/tb_lc3_mio_gen.sv
// Directed self-checking bench for lc3_mio_gen (MEM_LAT=3, KB_DEPTH=4, DEV_BASE=16'hFE00).
module tb_lc3_mio_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] DATABUS = '0;
    logic        MIO_EN = 1'b0, R_W = 1'b0, LD_MAR = 1'b0, LD_MDR = 1'b0, GateMDR = 1'b1;
    logic [15:0] MDRbus_out;
    logic        R, KB_INT;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        kb_ready;
    logic        disp_ready = 1'b0;
    logic        LD_char;
    logic [7:0]  I_char;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    lc3_mio_gen #(.MEM_LAT(3), .KB_DEPTH(4), .DEV_BASE(16'hFE00)) dut (
        .clk(clk), .reset(reset), .DATABUS(DATABUS), .MIO_EN(MIO_EN), .R_W(R_W),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .GateMDR(GateMDR), .MDRbus_out(MDRbus_out),
        .R(R), .KB_INT(KB_INT), .kb_valid(kb_valid), .kb_data(kb_data),
        .kb_ready(kb_ready), .disp_ready(disp_ready), .LD_char(LD_char), .I_char(I_char),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] a);
        DATABUS = a; LD_MAR = 1'b1; cyc(1); LD_MAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        DATABUS = v; LD_MDR = 1'b1; cyc(1); LD_MDR = 1'b0;
    endtask

    task automatic access(input logic rw, output int lat, output int en_cnt, output int we_cnt,
                          output int ld_cnt, output logic [15:0] addr_s,
                          output logic [15:0] wdata_s);
        lat = 0; en_cnt = 0; we_cnt = 0; ld_cnt = 0; addr_s = '0; wdata_s = '0;
        MIO_EN = 1'b1; R_W = rw; LD_MDR = !rw;
        while (lat < 20) begin
            cyc(1);
            lat++;
            if (mem_en) begin
                en_cnt++; addr_s = mem_addr; wdata_s = mem_wdata;
            end
            if (mem_we) we_cnt++;
            if (LD_char) ld_cnt++;
            if (R) break;
        end
        cyc(1);
        if (LD_char) ld_cnt++;
        check("r_held", 16'(R), 16'h1);
        MIO_EN = 1'b0; LD_MDR = 1'b0; R_W = 1'b0;
        cyc(1);
        check("r_drop", 16'(R), 16'h0);
    endtask

    task automatic dev_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        int lat, en, we, ld;
        logic [15:0] ad, wd;
        set_mar(a);
        access(1'b0, lat, en, we, ld, ad, wd);
        check(tag, MDRbus_out, exp);
        check({tag, "_lat"}, 16'(lat), 16'd1);
    endtask

    int lat, en, we, ld;
    logic [15:0] ad, wd;

    initial begin
        cyc(2);
        check("rst_r", 16'(R), 16'h0);
        check("rst_mem_en", 16'(mem_en), 16'h0);
        check("rst_mdr", MDRbus_out, 16'h0000);
        check("rst_kb_ready", 16'(kb_ready), 16'h1);
        check("rst_ld_char", 16'(LD_char), 16'h0);
        check("rst_i_char", 16'(I_char), 16'h00);
        check("rst_kb_int", 16'(KB_INT), 16'h0);
        reset = 1'b1;
        cyc(1);

        // Memory read
        set_mar(16'h0100);
        mem_rdata = 16'hBEEF;
        access(1'b0, lat, en, we, ld, ad, wd);
        check("rd_lat", 16'(lat), 16'd4);
        check("rd_en_cycles", 16'(en), 16'd3);
        check("rd_we_cycles", 16'(we), 16'd0);
        check("rd_addr", ad, 16'h0100);
        check("rd_mdr", MDRbus_out, 16'hBEEF);
        GateMDR = 1'b0; #1;
        check("gate_off", MDRbus_out, 16'h0000);
        GateMDR = 1'b1;

        // Memory write
        load_mdr(16'h1234);
        set_mar(16'h3000);
        access(1'b1, lat, en, we, ld, ad, wd);
        check("wr_lat", 16'(lat), 16'd4);
        check("wr_en_cycles", 16'(en), 16'd3);
        check("wr_we_cycles", 16'(we), 16'd3);
        check("wr_addr", ad, 16'h3000);
        check("wr_wdata", wd, 16'h1234);

        // Reset in the middle of MEM_WAIT
        load_mdr(16'h5555);
        set_mar(16'h0200);
        MIO_EN = 1'b1; R_W = 1'b1;
        cyc(2);
        check("mid_mem_en", 16'(mem_en), 16'h1);
        reset = 1'b0;
        cyc(1);
        check("mrst_r", 16'(R), 16'h0);
        check("mrst_mem_en", 16'(mem_en), 16'h0);
        check("mrst_mdr", MDRbus_out, 16'h0000);
        cyc(1);
        reset = 1'b1; MIO_EN = 1'b0; R_W = 1'b0;
        cyc(1);
        check("mrst_idle_en", 16'(mem_en), 16'h0);
        check("mrst_addr", mem_addr, 16'h0000);
        dev_read("post_rst_dsr", 16'hFE04, 16'h0000);

        // Keyboard FIFO
        kb_valid = 1'b1; kb_data = 8'h41; cyc(1);
        kb_data = 8'h42; cyc(1);
        kb_valid = 1'b0;
        dev_read("kbsr_full", 16'hFE00, 16'h8000);
        dev_read("kbdr_0", 16'hFE02, 16'h0041);
        dev_read("kbdr_1", 16'hFE02, 16'h0042);
        dev_read("kbsr_empty", 16'hFE00, 16'h0000);
        dev_read("kbdr_empty", 16'hFE02, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            kb_data = 8'(8'h61 + i);
            kb_valid = 1'b1;
            check("kb_ready_fill", 16'(kb_ready), (i < 4) ? 16'h1 : 16'h0);
            cyc(1);
        end
        kb_valid = 1'b0;
        for (int i = 0; i < 4; i++) dev_read("kbdr_wrap", 16'hFE02, 16'(8'h61 + i));
        dev_read("kbdr_lost5", 16'hFE02, 16'h0000);
        check("kb_ready_drained", 16'(kb_ready), 16'h1);

        // Display
        disp_ready = 1'b1;
        dev_read("dsr_ready", 16'hFE04, 16'h8000);
        load_mdr(16'h0058);
        set_mar(16'hFE06);
        access(1'b1, lat, en, we, ld, ad, wd);
        check("ddr_lat", 16'(lat), 16'd1);
        check("ddr_pulse", 16'(ld), 16'd1);
        check("ddr_char", 16'(I_char), 16'h0058);
        check("ddr_no_mem", 16'(en), 16'd0);
        disp_ready = 1'b0;
        load_mdr(16'h0059);
        access(1'b1, lat, en, we, ld, ad, wd);
        check("ddr_busy_lat", 16'(lat), 16'd1);
        check("ddr_busy_pulse", 16'(ld), 16'd0);
        check("ddr_busy_char", 16'(I_char), 16'h0058);
        dev_read("dsr_busy", 16'hFE04, 16'h0000);
        dev_read("odd_dev", 16'hFE01, 16'h0000);

        // Keyboard interrupt
        load_mdr(16'h4000);
        set_mar(16'hFE00);
        access(1'b1, lat, en, we, ld, ad, wd);
        kb_valid = 1'b1; kb_data = 8'h31; cyc(1);
        kb_valid = 1'b0; cyc(1);
`ifdef MIO_KB_INT_EN
        check("kb_int_set", 16'(KB_INT), 16'h1);
        dev_read("kbsr_ie", 16'hFE00, 16'hC000);
        dev_read("kbdr_int", 16'hFE02, 16'h0031);
        check("kb_int_clr", 16'(KB_INT), 16'h0);
`else
        check("kb_int_off", 16'(KB_INT), 16'h0);
        dev_read("kbsr_no_ie", 16'hFE00, 16'h8000);
        dev_read("kbdr_int", 16'hFE02, 16'h0031);
        check("kb_int_off2", 16'(KB_INT), 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
